// File: rtl/cfg_pkg.sv
// -----------------------------------------------------------------------------
// cfg_pkg
//   Shared constants and the sequencer state type for the config latch bank
//   loader. The latch bank holds NUM_WORDS slots of WORD_W bits each
//   (14 x 32 = 448 config bits).
// -----------------------------------------------------------------------------
package cfg_pkg;

  localparam int WORD_W     = 32;
  localparam int NUM_WORDS  = 14;
  localparam int ADDR_W     = $clog2(NUM_WORDS);
  localparam int STROBE_CYC = 2;

  // Per-word sequence: WAIT (handshake) -> SETUP -> STROBE x STROBE_CYC -> HOLD.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    SETUP  = 3'd2,
    STROBE = 3'd3,
    HOLD   = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/cfg_onehot_dec.sv
// -----------------------------------------------------------------------------
// cfg_onehot_dec
//   Gated binary-to-one-hot decoder for latch slot selection.
//   Ports:
//     addr    in   ADDR_W     slot index
//     gate    in   1          when low the output is all zeros
//     onehot  out  NUM_WORDS  bit addr set when gate is high and addr is in range
//   Indices >= NUM_WORDS decode to all zeros, so a bad index can never open
//   a latch.
// -----------------------------------------------------------------------------
module cfg_onehot_dec #(
  parameter int ADDR_W    = cfg_pkg::ADDR_W,
  parameter int NUM_WORDS = cfg_pkg::NUM_WORDS
) (
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 gate,
  output logic [NUM_WORDS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (gate && (addr == ADDR_W'(i))) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/configs_loader.sv
// -----------------------------------------------------------------------------
// configs_loader
//   Sequencer for the transparent config latch bank. Takes config words from
//   a valid/ready stream, places each on the shared bank data bus and pulses
//   the matching slot enable with a SETUP cycle before and a HOLD cycle after
//   the strobe, so every latch closes on stable data.
//   Ports:
//     clk            in   1          rising-edge clock
//     reset          in   1          synchronous, active-high
//     io_start       in   1          begin a load (honoured only in IDLE)
//     io_start_addr  in   ADDR_W     first slot; load runs start_addr..NUM_WORDS-1
//     io_in_valid    in   1          config word available
//     io_in_ready    out  1          word accepted this cycle (WAIT only)
//     io_in_bits     in   WORD_W     config word
//     io_d_out       out  WORD_W     latch bank data bus
//     io_configs_en  out  NUM_WORDS  latch bank enables, at most one high
//     io_busy        out  1          sequence in progress
//     io_done        out  1          one-cycle pulse after the last HOLD
//     io_err         out  1          sticky bad start address flag
//   Every output is a register; nothing combinational reaches the bank.
// -----------------------------------------------------------------------------
module configs_loader #(
  parameter int WORD_W     = cfg_pkg::WORD_W,
  parameter int NUM_WORDS  = cfg_pkg::NUM_WORDS,
  parameter int STROBE_CYC = cfg_pkg::STROBE_CYC,
  parameter int ADDR_W     = cfg_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic [ADDR_W-1:0]    io_start_addr,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [WORD_W-1:0]    io_in_bits,
  output logic [WORD_W-1:0]    io_d_out,
  output logic [NUM_WORDS-1:0] io_configs_en,
  output logic                 io_busy,
  output logic                 io_done,
  output logic                 io_err
);

  import cfg_pkg::*;

  localparam int                TMR_W      = $clog2(STROBE_CYC + 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD   = TMR_W'(STROBE_CYC);
  localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_SLOT  = ADDR_W'(NUM_WORDS - 1);
  // One extra bit so the range check stays correct if NUM_WORDS == 2**ADDR_W.
  localparam logic [ADDR_W:0]   SLOT_LIMIT = (ADDR_W + 1)'(NUM_WORDS);

  state_t                state;
  logic [ADDR_W-1:0]     slot;
  logic [TMR_W-1:0]      tmr;
  logic [NUM_WORDS-1:0]  slot_onehot;
  logic                  addr_ok;

  assign addr_ok = ({1'b0, io_start_addr} < SLOT_LIMIT);

  // Decoded enable is only consumed on the SETUP -> STROBE edge; gating it
  // by SETUP keeps the decoder output zero everywhere else.
  cfg_onehot_dec #(
    .ADDR_W    (ADDR_W),
    .NUM_WORDS (NUM_WORDS)
  ) u_slot_dec (
    .addr   (slot),
    .gate   (state == SETUP),
    .onehot (slot_onehot)
  );

  // Outputs are assigned on the edge that enters each state, so the
  // registered value always matches the state being occupied.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      slot          <= '0;
      tmr           <= '0;
      io_d_out      <= '0;
      io_configs_en <= '0;
      io_in_ready   <= 1'b0;
      io_busy       <= 1'b0;
      io_done       <= 1'b0;
      io_err        <= 1'b0;
    end else begin
      io_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (io_start) begin
            if (addr_ok) begin
              slot        <= io_start_addr;
              io_err      <= 1'b0;
              io_in_ready <= 1'b1;
              io_busy     <= 1'b1;
              state       <= WAIT;
            end else begin
              // Bad address: flag it and stay put; no enable is ever raised.
              io_err <= 1'b1;
            end
          end
        end

        WAIT: begin
          // The bus only changes here, and no enable is high in WAIT.
          if (io_in_valid && io_in_ready) begin
            io_d_out    <= io_in_bits;
            io_in_ready <= 1'b0;
            state       <= SETUP;
          end
        end

        SETUP: begin
          tmr           <= TMR_LOAD;
          io_configs_en <= slot_onehot;
          state         <= STROBE;
        end

        STROBE: begin
          tmr <= tmr - TMR_LAST;
          if (tmr == TMR_LAST) begin
            io_configs_en <= '0;
            state         <= HOLD;
          end
        end

        HOLD: begin
          // Slot stops at the last index rather than wrapping.
          if (slot == LAST_SLOT) begin
            io_done <= 1'b1;
            state   <= DONE;
          end else begin
            slot        <= slot + ADDR_W'(1);
            io_in_ready <= 1'b1;
            state       <= WAIT;
          end
        end

        DONE: begin
          io_busy <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          io_configs_en <= '0;
          io_in_ready   <= 1'b0;
          io_busy       <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  // Bank-side safety properties.
  a_en_onehot0 : assert property (@(posedge clk) $onehot0(io_configs_en));
  a_bus_stable : assert property (@(posedge clk) disable iff (reset)
                                  (|io_configs_en) |-> $stable(io_d_out));

endmodule

// File: tb/tb_configs_loader.sv
// -----------------------------------------------------------------------------
// tb_configs_loader
//   Randomized bench for configs_loader. The reference is a transaction view
//   of a load: for start slot a and words W[0..n-1], the bank must see exactly
//   n strobes, strobe i on slot a+i carrying W[i] for STROBE_CYC cycles, one
//   done pulse, and with valid held the done pulse lands (3+STROBE_CYC)*n+1
//   clock edges after start is driven.
// -----------------------------------------------------------------------------
module tb_configs_loader;
  import cfg_pkg::*;

  localparam int S = STROBE_CYC;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 io_start;
  logic [ADDR_W-1:0]    io_start_addr;
  logic                 io_in_valid;
  logic                 io_in_ready;
  logic [WORD_W-1:0]    io_in_bits;
  logic [WORD_W-1:0]    io_d_out;
  logic [NUM_WORDS-1:0] io_configs_en;
  logic                 io_busy;
  logic                 io_done;
  logic                 io_err;

  always #5 clk = ~clk;

  configs_loader dut (
    .clk           (clk),
    .reset         (reset),
    .io_start      (io_start),
    .io_start_addr (io_start_addr),
    .io_in_valid   (io_in_valid),
    .io_in_ready   (io_in_ready),
    .io_in_bits    (io_in_bits),
    .io_d_out      (io_d_out),
    .io_configs_en (io_configs_en),
    .io_busy       (io_busy),
    .io_done       (io_done),
    .io_err        (io_err)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observed strobes on the bank side, one record per enable pulse.
  typedef struct {
    int                slot;
    logic [WORD_W-1:0] data;
    int                len;
  } strobe_t;

  strobe_t              strobes[$];
  int                   edges     = 0;
  int                   done_cnt  = 0;
  int                   done_edge = 0;
  logic [NUM_WORDS-1:0] prev_en   = '0;
  logic [WORD_W-1:0]    prev_d    = '0;

  always @(posedge clk) edges++;

  always @(negedge clk) begin
    strobe_t t;
    int      idx;
    if (io_configs_en != '0) begin
      check("en_onehot", 64'($onehot(io_configs_en)), 64'd1);
      if (io_configs_en == prev_en) begin
        check("d_stable_in_strobe", 64'(io_d_out), 64'(prev_d));
        if (strobes.size() > 0) begin
          t = strobes.pop_back();
          t.len++;
          strobes.push_back(t);
        end
      end else begin
        idx = -1;
        for (int i = 0; i < NUM_WORDS; i++) if (io_configs_en[i]) idx = i;
        t.slot = idx;
        t.data = io_d_out;
        t.len  = 1;
        strobes.push_back(t);
      end
    end
    if (io_done) begin
      done_cnt++;
      done_edge = edges;
    end
    prev_en = io_configs_en;
    prev_d  = io_d_out;
  end

  logic [WORD_W-1:0] wq[$];       // words for the next load
  logic [WORD_W-1:0] last_word;   // what the bus should be holding

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full load from slot addr using the words in wq. max_gap > 0 stalls
  // valid in WAIT (first word always by max_gap cycles), offers junk while
  // the loader is not ready, and pulses a bad io_start while busy.
  task automatic do_load(input int addr, input int max_gap);
    int n, e0, g, gap;
    n = NUM_WORDS - addr;
    strobes.delete();
    done_cnt      = 0;
    io_start      = 1'b1;
    io_start_addr = ADDR_W'(addr);
    if (max_gap > 0) begin
      io_in_valid = 1'b1;
      io_in_bits  = WORD_W'($urandom);
    end
    e0 = edges;
    tick();
    io_start = 1'b0;
    check("start_busy", 64'(io_busy), 64'd1);
    check("start_err_clear", 64'(io_err), 64'd0);
    for (int k = 0; k < n; k++) begin
      if (max_gap > 0) begin
        io_in_valid   = 1'b1;
        io_in_bits    = WORD_W'($urandom);
        io_start      = 1'b1;
        io_start_addr = '1;
      end else begin
        io_in_valid = 1'b1;
        io_in_bits  = wq[k];
      end
      g = 0;
      while (!io_in_ready && g < 64) begin
        tick();
        g++;
      end
      check("ready_timeout", 64'(g < 64), 64'd1);
      io_start = 1'b0;
      if (max_gap > 0) begin
        gap = (k == 0) ? max_gap : int'($urandom_range(0, max_gap));
        io_in_valid = 1'b0;
        repeat (gap) begin
          tick();
          check("stall_ready", 64'(io_in_ready), 64'd1);
          check("stall_en", 64'(io_configs_en), 64'd0);
          check("stall_dout", 64'(io_d_out), 64'(last_word));
        end
      end
      io_in_valid = 1'b1;
      io_in_bits  = wq[k];
      tick();
      last_word = wq[k];
      check("captured", 64'(io_d_out), 64'(wq[k]));
      check("ready_drop", 64'(io_in_ready), 64'd0);
    end
    io_in_valid = 1'b0;
    g = 0;
    while (done_cnt == 0 && g < 64) begin
      tick();
      g++;
    end
    check("done_timeout", 64'(g < 64), 64'd1);
    repeat (3) tick();
    check("done_once", 64'(done_cnt), 64'd1);
    if (max_gap == 0) check("latency", 64'(done_edge - e0), 64'((3 + S) * n + 1));
    check("idle_busy", 64'(io_busy), 64'd0);
    check("idle_ready", 64'(io_in_ready), 64'd0);
    check("idle_dout", 64'(io_d_out), 64'(last_word));
    check("idle_err", 64'(io_err), 64'd0);
    check("strobe_count", 64'(strobes.size()), 64'(n));
    for (int i = 0; i < n && i < strobes.size(); i++) begin
      check("strobe_slot", 64'(strobes[i].slot), 64'(addr + i));
      check("strobe_data", 64'(strobes[i].data), 64'(wq[i]));
      check("strobe_len", 64'(strobes[i].len), 64'(S));
    end
  endtask

  task automatic fill_random(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back(WORD_W'($urandom));
  endtask

  initial begin
    int addr, k, g;
    logic hs;
    reset         = 1'b1;
    io_start      = 1'b0;
    io_start_addr = '0;
    io_in_valid   = 1'b0;
    io_in_bits    = '0;
    last_word     = '0;
    repeat (3) tick();
    check("rst_en", 64'(io_configs_en), 64'd0);
    check("rst_dout", 64'(io_d_out), 64'd0);
    check("rst_ready", 64'(io_in_ready), 64'd0);
    check("rst_busy", 64'(io_busy), 64'd0);
    check("rst_done", 64'(io_done), 64'd0);
    check("rst_err", 64'(io_err), 64'd0);
    reset = 1'b0;

    // Words offered before any start must not be consumed.
    io_in_valid = 1'b1;
    io_in_bits  = 32'hDEAD_BEEF;
    repeat (3) begin
      tick();
      check("pre_start_ready", 64'(io_in_ready), 64'd0);
      check("pre_start_busy", 64'(io_busy), 64'd0);
    end

    // Full load with valid held.
    wq.delete();
    for (int i = 0; i < NUM_WORDS; i++) wq.push_back(32'hA000_0000 + 32'(i));
    do_load(0, 0);

    // Partial load of the top two slots.
    wq.delete();
    wq.push_back(32'h11);
    wq.push_back(32'h22);
    do_load(12, 0);

    // Bad address then a good one clears the flag.
    strobes.delete();
    io_start      = 1'b1;
    io_start_addr = ADDR_W'(NUM_WORDS);
    tick();
    io_start = 1'b0;
    check("bad_err", 64'(io_err), 64'd1);
    check("bad_busy", 64'(io_busy), 64'd0);
    check("bad_ready", 64'(io_in_ready), 64'd0);
    repeat (4) tick();
    check("bad_no_strobe", 64'(strobes.size()), 64'd0);
    check("bad_err_sticky", 64'(io_err), 64'd1);
    fill_random(NUM_WORDS - 3);
    do_load(3, 7);

    // Random loads with random stalls.
    repeat (4) begin
      addr = int'($urandom_range(0, NUM_WORDS - 1));
      fill_random(NUM_WORDS - addr);
      do_load(addr, int'($urandom_range(0, 7)));
    end

    // Reset during the strobe of slot 5.
    strobes.delete();
    io_start      = 1'b1;
    io_start_addr = '0;
    tick();
    io_start    = 1'b0;
    k           = 0;
    io_in_valid = 1'b1;
    io_in_bits  = 32'hC000_0000;
    g           = 0;
    while (!io_configs_en[5] && g < 200) begin
      hs = io_in_ready;
      tick();
      g++;
      if (hs) begin
        k++;
        io_in_bits = 32'hC000_0000 + 32'(k);
      end
    end
    check("reach_slot5", 64'(g < 200), 64'd1);
    check("slot5_data", 64'(io_d_out), 64'h0000_0000_C000_0005);
    reset       = 1'b1;
    io_in_valid = 1'b0;
    tick();
    reset = 1'b0;
    check("mid_rst_en", 64'(io_configs_en), 64'd0);
    check("mid_rst_dout", 64'(io_d_out), 64'd0);
    check("mid_rst_busy", 64'(io_busy), 64'd0);
    check("mid_rst_ready", 64'(io_in_ready), 64'd0);
    check("mid_rst_done", 64'(io_done), 64'd0);
    last_word = '0;
    tick();
    fill_random(NUM_WORDS);
    do_load(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #400000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
